// File: rtl/x_uart_tx.sv
// x_uart_tx: buffered 8N1 UART transmitter.
// Bytes enter a small circular FIFO over a valid/ready handshake and are
// serialised LSB first on o_tx. Bit timing matches the team UART receiver:
// every bit lasts (p_clk_hz/p_baud)+1 clock cycles.
//
// state    | meaning
// ---------+----------------------------------------------------------
// st_idle  | line high, waiting for the FIFO to become non-empty
// st_start | start bit (line low)
// st_d0..7 | data bit n on the line, shift register drives o_tx
// st_stop  | stop bit (line high); pops the next byte if one is queued
module x_uart_tx #(
  parameter int p_clk_hz     = 1200000,
  parameter int p_baud       = 115200,
  parameter int p_fifo_depth = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int timer_top = p_clk_hz / p_baud;
  localparam int tw        = $clog2(timer_top + 1);
  localparam int aw        = $clog2(p_fifo_depth);

  localparam logic [tw-1:0] timer_top_v = tw'(timer_top);
  localparam logic [aw:0]   depth_v     = (aw + 1)'(p_fifo_depth);

  localparam logic [3:0] st_idle  = 4'd0;
  localparam logic [3:0] st_start = 4'd1;
  localparam logic [3:0] st_d0    = 4'd2;
  localparam logic [3:0] st_d7    = 4'd9;
  localparam logic [3:0] st_stop  = 4'd10;

  logic [3:0]    state;
  logic [tw-1:0] timer;
  logic [7:0]    shift;
  logic          tx_q;

  logic [7:0]    mem [p_fifo_depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [aw:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic tick;
  logic [7:0] head;

  // Handshake, FIFO status and the pop decision shared by FSM and FIFO.
  always_comb begin
    full  = (count == depth_v);
    empty = (count == '0);
    tick  = (timer == timer_top_v);
    head  = mem[rd_ptr];
    // Ready is gated by reset so the host never sees a stale accept.
    o_ready = ~full & i_rst_n;
    push    = i_valid & o_ready;
    // Idle pops immediately; stop pops at its last cycle so frames abut.
    pop = ~empty & ((state == st_idle) | ((state == st_stop) & tick));
    o_tx   = tx_q;
    o_busy = (state != st_idle) | ~empty;
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bit timer: parked at zero in idle, otherwise wraps at timer_top.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer <= '0;
    end else if (state == st_idle || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Frame sequencer; o_tx is registered alongside the state so the line
  // level changes on exactly the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= st_idle;
      shift <= 8'h00;
      tx_q  <= 1'b1;
    end else begin
      case (state)
        st_idle: begin
          if (pop) begin
            shift <= head;
            state <= st_start;
            tx_q  <= 1'b0;
          end
        end
        st_start: begin
          if (tick) begin
            state <= st_d0;
            tx_q  <= shift[0];
          end
        end
        st_stop: begin
          if (tick) begin
            if (pop) begin
              shift <= head;
              state <= st_start;
              tx_q  <= 1'b0;
            end else begin
              state <= st_idle;
              tx_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (state >= st_d0 && state <= st_d7) begin
            if (tick) begin
              shift <= {1'b0, shift[7:1]};
              if (state == st_d7) begin
                state <= st_stop;
                tx_q  <= 1'b1;
              end else begin
                state <= state + 4'd1;
                tx_q  <= shift[1];
              end
            end
          end else begin
            // Unreachable encodings recover to a quiet line.
            state <= st_idle;
            tx_q  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
